// File: rtl/encoder_value_controller_pkg.sv
// Shared types and constants for the encoder-driven BCD value editor:
// controller modes, BCD limits and the 7-segment encoding table.
package encoder_value_controller_pkg;

    typedef enum logic {
        VIEW = 1'b0,
        EDIT = 1'b1
    } mode_e;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Segment order is a=bit0 .. g=bit6, active high.
    function automatic logic [6:0] seg7_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d == BCD_MAX) ? BCD_MIN : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/encoder_value_controller_if.sv
// Pin-level bundle between the controller and the board wrapper:
// raw encoder/button inputs plus the edited value and display drive.
interface encoder_value_controller_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int CW = $clog2(NUM_DIGITS);

    logic                    enc_a;
    logic                    enc_b;
    logic                    btn;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    edit;
    logic [CW-1:0]           cursor;
    logic [CW-1:0]           digit_idx;
    logic [6:0]              seg;
    logic                    dp;

    modport master (
        output enc_a, enc_b, btn,
        input  value, edit, cursor, digit_idx, seg, dp
    );

    modport slave (
        input  enc_a, enc_b, btn,
        output value, edit, cursor, digit_idx, seg, dp
    );

endinterface

// File: rtl/encoder_edge_detect.sv
// Synchronises an asynchronous pin, detects its rising edge and blocks
// further edges for LOCKOUT cycles; also synchronises a companion direction pin.
module encoder_edge_detect #(
    parameter int LOCKOUT = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    input  logic dir_in,
    output logic evt,
    output logic dir
);
    localparam int LW = $clog2(LOCKOUT + 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT);
    localparam logic [LW-1:0] LOCK_ZERO = {LW{1'b0}};

    logic [1:0]    sig_sync_q, sig_sync_d;
    logic [1:0]    dir_sync_q, dir_sync_d;
    logic          sig_prev_q, sig_prev_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          evt_s;

    // Edge detection and lockout bookkeeping; the previous value tracks
    // the synced pin every cycle so a held level never re-triggers.
    always_comb begin
        sig_sync_d = {sig_sync_q[0], sig_in};
        dir_sync_d = {dir_sync_q[0], dir_in};
        sig_prev_d = sig_sync_q[1];
        evt_s      = sig_sync_q[1] & ~sig_prev_q & (lock_q == LOCK_ZERO);
        if (evt_s) begin
            lock_d = LOCK_LOAD;
        end else if (lock_q != LOCK_ZERO) begin
            lock_d = lock_q - {{(LW-1){1'b0}}, 1'b1};
        end else begin
            lock_d = lock_q;
        end
    end

    // Synchronisers and previous value reset high to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_sync_q <= 2'b11;
            dir_sync_q <= 2'b11;
            sig_prev_q <= 1'b1;
            lock_q     <= LOCK_ZERO;
        end else begin
            sig_sync_q <= sig_sync_d;
            dir_sync_q <= dir_sync_d;
            sig_prev_q <= sig_prev_d;
            lock_q     <= lock_d;
        end
    end

    assign evt = evt_s;
    assign dir = dir_sync_q[1];

endmodule

// File: rtl/seg7.sv
// BCD digit to active-high 7-segment decoder; non-BCD codes blank the digit.
module seg7
    import encoder_value_controller_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup shared with the rest of the display path.
    always_comb begin
        seg = seg7_encode(digit);
    end

endmodule

// File: rtl/encoder_value_controller.sv
// VIEW/EDIT controller: the button walks a cursor over the BCD digits, encoder
// steps change the selected digit, and the value is scanned onto one 7-seg digit.
module encoder_value_controller
    import encoder_value_controller_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int LOCKOUT    = 125,
    parameter int SCAN_DIV   = 16
) (
    input logic clk,
    input logic reset,
    encoder_value_controller_if.slave bus
);
    localparam int CW = $clog2(NUM_DIGITS);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CUR_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CUR_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SCAN_ZERO  = {SW{1'b0}};
    localparam logic [SW-1:0] SCAN_ONE   = {{(SW-1){1'b0}}, 1'b1};

    logic step_s, step_dn_s, press_s, btn_dir_unused;

    mode_e                      mode_q, mode_d;
    logic [CW-1:0]              cursor_q, cursor_d;
    logic [CW-1:0]              digit_idx_q, digit_idx_d;
    logic [SW-1:0]              scan_cnt_q, scan_cnt_d;
    logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
    logic [3:0]                 cur_digit_s, shown_digit_s;
    logic [6:0]                 seg_s;

    encoder_edge_detect #(.LOCKOUT(LOCKOUT)) u_enc_a (
        .clk    (clk),
        .reset  (reset),
        .sig_in (bus.enc_a),
        .dir_in (bus.enc_b),
        .evt    (step_s),
        .dir    (step_dn_s)
    );

    encoder_edge_detect #(.LOCKOUT(LOCKOUT)) u_btn (
        .clk    (clk),
        .reset  (reset),
        .sig_in (bus.btn),
        .dir_in (1'b0),
        .evt    (press_s),
        .dir    (btn_dir_unused)
    );

    // Mode, cursor and digit edits; a simultaneous step and press edits the
    // old cursor digit and advances the cursor on the same edge.
    always_comb begin
        mode_d      = mode_q;
        cursor_d    = cursor_q;
        digits_d    = digits_q;
        cur_digit_s = digits_q[cursor_q];
        case (mode_q)
            VIEW: begin
                if (press_s) begin
                    mode_d   = EDIT;
                    cursor_d = CUR_ZERO;
                end else begin
                    mode_d   = VIEW;
                end
            end
            EDIT: begin
                if (step_s) begin
                    digits_d[cursor_q] = step_dn_s ? bcd_dec(cur_digit_s)
                                                   : bcd_inc(cur_digit_s);
                end else begin
                    digits_d = digits_q;
                end
                if (press_s) begin
                    if (cursor_q == LAST_DIGIT) begin
                        mode_d   = VIEW;
                        cursor_d = CUR_ZERO;
                    end else begin
                        cursor_d = cursor_q + CUR_ONE;
                    end
                end else begin
                    cursor_d = cursor_q;
                end
            end
            default: begin
                mode_d   = VIEW;
                cursor_d = CUR_ZERO;
            end
        endcase
    end

    // Free-running display scan.
    always_comb begin
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d  = SCAN_ZERO;
            digit_idx_d = (digit_idx_q == LAST_DIGIT) ? CUR_ZERO : digit_idx_q + CUR_ONE;
        end else begin
            scan_cnt_d  = scan_cnt_q + SCAN_ONE;
            digit_idx_d = digit_idx_q;
        end
    end

    // Controller state; reset discards any edit in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= VIEW;
            cursor_q    <= CUR_ZERO;
            digits_q    <= '{default: BCD_MIN};
            scan_cnt_q  <= SCAN_ZERO;
            digit_idx_q <= CUR_ZERO;
        end else begin
            mode_q      <= mode_d;
            cursor_q    <= cursor_d;
            digits_q    <= digits_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    assign shown_digit_s = digits_q[digit_idx_q];

    seg7 u_seg7 (
        .digit (shown_digit_s),
        .seg   (seg_s)
    );

    assign bus.value     = digits_q;
    assign bus.edit      = (mode_q == EDIT);
    assign bus.cursor    = cursor_q;
    assign bus.digit_idx = digit_idx_q;
    assign bus.seg       = seg_s;
    assign bus.dp        = (mode_q == EDIT) && (digit_idx_q == cursor_q);

endmodule
